rf_read_sequencer: RTL and testbench

//  - Sequences two-operand register-file reads through the single 16:1 read port (rs1 mux).
//  - Accepts one {ra, rb} request at a time, drives the mux select for ra then rb, and captures
//    the mux output each cycle. Returns both operands together on a valid/ready response.
//  - Sits between the decode/issue stage and the register-file read mux.

---
 rtl/rf_read_sequencer_if.sv | 55 +++++
 rtl/rf_read_sequencer.sv | 134 +++++++++++++
 tb/tb_rf_read_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_read_sequencer_if.sv
// rf_read_sequencer_if
//   Bundles the request, read-mux and response signals of the register-file
//   read sequencer.
//   slave  : sequencer side (rf_read_sequencer)
//   master : issue stage / register-file side
//   Ports carried:
//     req_valid/req_ready/req_ra/req_rb   operand request handshake
//     rd_sel/rd_data                      16:1 read-mux select and data
//     resp_valid/resp_ready/resp_a/resp_b operand response handshake
//     busy                                sequencer not idle
//     wb_en/wb_sel/wb_data                write-back snoop (RF_BYPASS_EN only)
//   Macro: RF_BYPASS_EN adds the write-back snoop signals.
interface rf_read_sequencer_if #(
    parameter int N   = 16,
    parameter int SEL = 4
);
    logic           req_valid;
    logic           req_ready;
    logic [SEL-1:0] req_ra;
    logic [SEL-1:0] req_rb;
    logic [SEL-1:0] rd_sel;
    logic [N-1:0]   rd_data;
    logic           resp_valid;
    logic           resp_ready;
    logic [N-1:0]   resp_a;
    logic [N-1:0]   resp_b;
    logic           busy;
`ifdef RF_BYPASS_EN
    logic           wb_en;
    logic [SEL-1:0] wb_sel;
    logic [N-1:0]   wb_data;

    modport slave (
        input  req_valid, req_ra, req_rb, rd_data, resp_ready,
        input  wb_en, wb_sel, wb_data,
        output req_ready, rd_sel, resp_valid, resp_a, resp_b, busy
    );

    modport master (
        output req_valid, req_ra, req_rb, rd_data, resp_ready,
        output wb_en, wb_sel, wb_data,
        input  req_ready, rd_sel, resp_valid, resp_a, resp_b, busy
    );
`else
    modport slave (
        input  req_valid, req_ra, req_rb, rd_data, resp_ready,
        output req_ready, rd_sel, resp_valid, resp_a, resp_b, busy
    );

    modport master (
        output req_valid, req_ra, req_rb, rd_data, resp_ready,
        input  req_ready, rd_sel, resp_valid, resp_a, resp_b, busy
    );
`endif
endinterface

// File: rtl/rf_read_sequencer.sv
// rf_read_sequencer
//   Sequences a two-operand {ra, rb} read through the single 16:1 register
//   file read port. One request is in flight at a time; ra is read first,
//   then rb (skipped when rb==ra), and both operands are returned together
//   on a valid/ready response.
//   Ports:
//     clk  : clock, all state on posedge
//     rst  : asynchronous active-high reset
//     bus  : rf_read_sequencer_if.slave (request, read mux, response, busy,
//            and write-back snoop when RF_BYPASS_EN is defined)
//   Macro: RF_BYPASS_EN -- a write-back hitting the register being read on a
//          capture edge is forwarded instead of the stale mux output.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | ready for a request, rd_sel parked at 0
//   RD_A  | rd_sel=ra, capture operand A (and B when ra==rb)
//   RD_B  | rd_sel=rb, capture operand B
//   RESP  | resp_valid high, operands held until resp_ready
module rf_read_sequencer #(
    parameter int N   = 16,
    parameter int SEL = 4
) (
    input  logic               clk,
    input  logic               rst,
    rf_read_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [SEL-1:0] ra_q;
    logic [SEL-1:0] rb_q;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [SEL-1:0] rd_sel_c;
    logic           req_ready_c;
    logic           resp_valid_c;
    logic           accept;
    logic [N-1:0]   cap_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_sel_c     = '0;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = RD_A;
                end
            end
            RD_A: begin
                rd_sel_c = ra_q;
                // A single read serves both operands when they name the same register.
                if (ra_q == rb_q) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = RD_B;
                end
            end
            RD_B: begin
                rd_sel_c  = rb_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Gate with rst so the issue stage never sees a handshake during reset.
    assign accept = req_ready_c && !rst && bus.req_valid;

`ifdef RF_BYPASS_EN
    // A write landing on the register under read this cycle would only reach
    // the mux after the capture edge, so take the write data directly.
    assign cap_data = (bus.wb_en && (bus.wb_sel == rd_sel_c)) ? bus.wb_data : bus.rd_data;
`else
    assign cap_data = bus.rd_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q <= '0;
            rb_q <= '0;
            op_a <= '0;
            op_b <= '0;
        end else begin
            if (accept) begin
                ra_q <= bus.req_ra;
                rb_q <= bus.req_rb;
            end
            if (state == RD_A) begin
                op_a <= cap_data;
                if (ra_q == rb_q) begin
                    op_b <= cap_data;
                end
            end
            if (state == RD_B) begin
                op_b <= cap_data;
            end
        end
    end

    assign bus.req_ready  = req_ready_c && !rst;
    assign bus.rd_sel     = rd_sel_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_a     = op_a;
    assign bus.resp_b     = op_b;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_rf_read_sequencer.sv
module tb_rf_read_sequencer;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_sel;
    logic [15:0] wb_data;
    logic [15:0] rf [16];

    int n_checks;
    int n_fail;

    rf_read_sequencer_if #(.N(16), .SEL(4)) bus ();

    rf_read_sequencer #(.N(16), .SEL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: mux is combinational, writes land on the clock edge.
    assign bus.rd_data = rf[bus.rd_sel];
    always @(posedge clk) begin
        if (wb_en) rf[wb_sel] <= wb_data;
    end

`ifdef RF_BYPASS_EN
    assign bus.wb_en   = wb_en;
    assign bus.wb_sel  = wb_sel;
    assign bus.wb_data = wb_data;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [3:0] sel, input logic [15:0] data);
        wb_en   = 1'b1;
        wb_sel  = sel;
        wb_data = data;
        step();
        wb_en   = 1'b0;
    endtask

    initial begin
        int n_acc;
        int acc_cyc [2];
        logic [15:0] last_a;
        logic [15:0] last_b;
        logic [15:0] exp_a;

        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        wb_en          = 1'b0;
        wb_sel         = '0;
        wb_data        = '0;
        bus.req_valid  = 1'b0;
        bus.req_ra     = '0;
        bus.req_rb     = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;

        // Reset state
        #2;
        chk("rst_req_ready",  bus.req_ready,  1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_busy",       bus.busy,       1'b0);
        chk("rst_rd_sel",     bus.rd_sel,     4'd0);
        chk("rst_resp_a",     bus.resp_a,     16'h0000);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("idle_req_ready", bus.req_ready, 1'b1);

        // Preload through the write port while idle
        rf_write(4'd1, 16'h0101);
        rf_write(4'd2, 16'h0202);
        rf_write(4'd3, 16'h1234);
        rf_write(4'd4, 16'h0404);
        rf_write(4'd5, 16'h00A5);
        rf_write(4'd6, 16'h0606);
        rf_write(4'd7, 16'hBEEF);
        rf_write(4'd9, 16'h9999);

        // Basic ra=3 rb=7, then backpressure
        bus.req_valid = 1'b1;
        bus.req_ra    = 4'd3;
        bus.req_rb    = 4'd7;
        step();
        bus.req_valid = 1'b0;
        bus.req_ra    = 4'd12;
        bus.req_rb    = 4'd13;
        chk("basic_rdsel_a", bus.rd_sel,     4'd3);
        chk("basic_busy",    bus.busy,       1'b1);
        chk("basic_rdy_a",   bus.req_ready,  1'b0);
        chk("basic_vld_e1",  bus.resp_valid, 1'b0);
        step();
        chk("basic_rdsel_b", bus.rd_sel,     4'd7);
        chk("basic_vld_e2p", bus.resp_valid, 1'b0);
        step();
        chk("basic_vld",     bus.resp_valid, 1'b1);
        chk("basic_a",       bus.resp_a,     16'h1234);
        chk("basic_b",       bus.resp_b,     16'hBEEF);

        bus.req_valid = 1'b1;
        bus.req_ra    = 4'd5;
        bus.req_rb    = 4'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_vld", bus.resp_valid, 1'b1);
            chk("bp_a",   bus.resp_a,     16'h1234);
            chk("bp_b",   bus.resp_b,     16'hBEEF);
            chk("bp_rdy", bus.req_ready,  1'b0);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk("bp_release_busy", bus.busy,       1'b0);
        chk("bp_release_vld",  bus.resp_valid, 1'b0);
        chk("bp_release_rdy",  bus.req_ready,  1'b1);
        chk("idle_hold_a",     bus.resp_a,     16'h1234);

        // Same register ra=rb=5 (request held pending from above)
        step();
        bus.req_valid = 1'b0;
        chk("same_busy",   bus.busy,   1'b1);
        chk("same_rdsel",  bus.rd_sel, 4'd5);
        step();
        chk("same_vld",    bus.resp_valid, 1'b1);
        chk("same_rdsel0", bus.rd_sel,     4'd0);
        chk("same_a",      bus.resp_a,     16'h00A5);
        chk("same_b",      bus.resp_b,     16'h00A5);
        bus.resp_ready = 1'b1;
        step();
        chk("same_done", bus.busy, 1'b0);

        // Back-to-back with resp_ready tied high
        n_acc         = 0;
        acc_cyc[0]    = -1;
        acc_cyc[1]    = -1;
        last_a        = '0;
        last_b        = '0;
        bus.req_valid = 1'b1;
        bus.req_ra    = 4'd1;
        bus.req_rb    = 4'd2;
        for (int cyc = 0; cyc < 12; cyc++) begin
            logic acc;
            acc = bus.req_ready && bus.req_valid;
            if (acc && n_acc < 2) acc_cyc[n_acc] = cyc;
            if (bus.resp_valid) begin
                last_a = bus.resp_a;
                last_b = bus.resp_b;
            end
            step();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    bus.req_ra = 4'd4;
                    bus.req_rb = 4'd6;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 4);
        chk("b2b_a",       last_a, 16'h0404);
        chk("b2b_b",       last_b, 16'h0606);
        chk("b2b_idle",    bus.busy, 1'b0);

        // Write to ra during RD_A
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_ra     = 4'd2;
        bus.req_rb     = 4'd9;
        step();
        bus.req_valid = 1'b0;
        chk("byp_rdsel", bus.rd_sel, 4'd2);
        wb_en   = 1'b1;
        wb_sel  = 4'd2;
        wb_data = 16'hCAFE;
        step();
        wb_en = 1'b0;
        step();
`ifdef RF_BYPASS_EN
        exp_a = 16'hCAFE;
`else
        exp_a = 16'h0202;
`endif
        chk("byp_vld", bus.resp_valid, 1'b1);
        chk("byp_a",   bus.resp_a,     exp_a);
        chk("byp_b",   bus.resp_b,     16'h9999);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;

        // Reset in the middle of RD_B
        bus.req_valid = 1'b1;
        bus.req_ra    = 4'd1;
        bus.req_rb    = 4'd3;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("mid_rdsel_b", bus.rd_sel, 4'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  bus.busy,       1'b0);
        chk("mid_rst_vld",   bus.resp_valid, 1'b0);
        chk("mid_rst_rdsel", bus.rd_sel,     4'd0);
        chk("mid_rst_a",     bus.resp_a,     16'h0000);
        chk("mid_rst_b",     bus.resp_b,     16'h0000);
        chk("mid_rst_rdy",   bus.req_ready,  1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", bus.req_ready, 1'b1);
        step();
        chk("post_rst_idle", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
